// File: rtl/hack_mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// Storage is zeroed after every reset before requests are accepted.
module hack_mem_responder #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [15:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [15:0]   rsp_rdata,
  output logic          rsp_write,
  output logic          init_done
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_clr_cnt;
  logic          r_rsp_valid, r_rsp_write, r_init_done;
  logic [15:0]   r_rsp_rdata;
  logic [15:0]   r_mem [DEPTH];

  logic          w_clr_last, w_req_ready, w_accept, w_mem_we;
  logic [AW-1:0] w_mem_waddr;
  logic [15:0]   w_mem_wdata;

  assign w_clr_last = (r_clr_cnt == AW'(DEPTH-1));

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_CLEAR;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (w_clr_last) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // The clear sweep and accepted writes share the single memory write port.
  always_comb begin
    w_req_ready = (r_state == S_RUN) && !reset && (!r_rsp_valid || rsp_ready);
    w_accept    = req_valid && w_req_ready;
    w_mem_we    = (r_state == S_CLEAR) || (w_accept && req_write);
    w_mem_waddr = (r_state == S_CLEAR) ? r_clr_cnt : req_addr;
    w_mem_wdata = (r_state == S_CLEAR) ? 16'h0000 : req_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset)                  r_clr_cnt <= '0;
    else if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset)                                  r_init_done <= 1'b0;
    else if (r_state == S_CLEAR && w_clr_last)  r_init_done <= 1'b1;
  end

  // Payload holds after consumption; only rsp_valid drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= 16'h0000;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_write <= req_write;
      r_rsp_rdata <= req_write ? req_wdata : r_mem[req_addr];
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_hack_mem_responder.sv
// Directed and random traffic against a transaction-level model of the responder.
module tb_hack_mem_responder;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clock = 1'b0;
  logic          reset, req_valid, req_write, rsp_ready;
  logic [AW-1:0] req_addr;
  logic [15:0]   req_wdata;
  logic          req_ready, rsp_valid, rsp_write, init_done;
  logic [15:0]   rsp_rdata;

  hack_mem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_write(rsp_write), .init_done(init_done)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Model: storage contents, pending response, and cycles spent clearing.
  logic [15:0] m_mem [DEPTH];
  logic        m_valid, m_write, m_init;
  logic [15:0] m_data;
  int          m_clr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_write = 1'b0; m_data = 16'h0; m_init = 1'b0; m_clr = 0;
  endtask

  // Drive one cycle: set inputs, check outputs before the edge, advance model at the edge.
  task automatic step(input logic rst, input logic v, input logic w,
                      input logic [AW-1:0] a, input logic [15:0] d, input logic rr);
    logic m_ready;
    reset = rst; req_valid = v; req_write = w; req_addr = a; req_wdata = d; rsp_ready = rr;
    #2;
    m_ready = m_init && !rst && (!m_valid || rr);
    chk("req_ready", {31'b0, req_ready}, {31'b0, m_ready});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
    chk("rsp_write", {31'b0, rsp_write}, {31'b0, m_write});
    chk("rsp_rdata", {16'b0, rsp_rdata}, {16'b0, m_data});
    chk("init_done", {31'b0, init_done}, {31'b0, m_init});
    @(posedge clock);
    if (rst) model_reset();
    else if (!m_init) begin
      m_clr++;
      if (m_clr == DEPTH) begin
        m_init = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0;
      end
    end else if (v && m_ready) begin
      m_valid = 1'b1;
      m_write = w;
      m_data  = w ? d : m_mem[a];
      if (w) m_mem[a] = d;
    end else if (m_valid && rr) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 16'h0, 1'b1);
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!init_done && n < 100) begin
      idle(1);
      n++;
    end
    chk(tag, n, DEPTH);
  endtask

  initial begin
    int lat;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    @(posedge clock); #1;
    model_reset();

    // Reset held one cycle, then the clear sweep runs to completion.
    step(1'b1, 1'b0, 1'b0, '0, 16'h0, 1'b1);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_init_done", {31'b0, init_done}, 32'd0);
    wait_init("init_latency");

    // Read of a freshly cleared word.
    step(1'b0, 1'b1, 1'b0, 6'd5, 16'hAAAA, 1'b1);
    chk("rd5_data", {16'b0, rsp_rdata}, 32'd0);
    chk("rd5_write", {31'b0, rsp_write}, 32'd0);
    idle(1);

    // Write then immediate read of the same address.
    step(1'b0, 1'b1, 1'b1, 6'd21, 16'hEC10, 1'b1);
    chk("wr21_ack", {31'b0, rsp_write}, 32'd1);
    chk("wr21_echo", {16'b0, rsp_rdata}, 32'h0000EC10);
    step(1'b0, 1'b1, 1'b0, 6'd21, 16'h0, 1'b1);
    chk("rd21_data", {16'b0, rsp_rdata}, 32'h0000EC10);
    idle(1);

    // Backpressure: response held while rsp_ready is low, competing request refused.
    step(1'b0, 1'b1, 1'b1, 6'd1, 16'd8, 1'b1);
    step(1'b0, 1'b1, 1'b0, 6'd1, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 6'd1, 16'hFFFF, 1'b0);
      chk("bp_data", {16'b0, rsp_rdata}, 32'd8);
      chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, '0, 16'h0, 1'b1);
    chk("bp_consumed", {31'b0, rsp_valid}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 6'd1, 16'h0, 1'b1);
    chk("bp_no_write", {16'b0, rsp_rdata}, 32'd8);

    // Back-to-back writes then reads of 20..25.
    for (int a = 20; a <= 25; a++) step(1'b0, 1'b1, 1'b1, AW'(a), 16'(16'h1100 + a), 1'b1);
    for (int a = 20; a <= 25; a++) begin
      step(1'b0, 1'b1, 1'b0, AW'(a), 16'h0, 1'b1);
      chk("b2b_data", {16'b0, rsp_rdata}, 32'h1100 + a);
    end
    idle(1);

    // Reset while a response is pending.
    step(1'b0, 1'b1, 1'b1, 6'd2, 16'h1234, 1'b1);
    step(1'b0, 1'b1, 1'b0, 6'd2, 16'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, 16'h0, 1'b0);
    chk("rst_drop_valid", {31'b0, rsp_valid}, 32'd0);
    wait_init("reinit_latency");
    step(1'b0, 1'b1, 1'b0, 6'd2, 16'h0, 1'b1);
    chk("rd2_cleared", {16'b0, rsp_rdata}, 32'd0);
    idle(1);

    // Requests during the clear sweep are ignored.
    step(1'b1, 1'b1, 1'b1, 6'd63, 16'hFFFF, 1'b1);
    lat = 0;
    while (!init_done && lat < 100) begin
      step(1'b0, 1'b1, 1'b1, 6'd63, 16'hFFFF, 1'b1);
      lat++;
    end
    chk("clr_latency", lat, DEPTH);
    step(1'b0, 1'b1, 1'b0, 6'd63, 16'h0, 1'b1);
    chk("rd63_cleared", {16'b0, rsp_rdata}, 32'd0);

    // Random traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 199) == 0), $urandom_range(0, 3) != 0, 1'($urandom),
           AW'($urandom), 16'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
